// File: rtl/seq_signed_multiplier.sv
// Sequential two's-complement shift-add multiplier: {X,Aval,Bval} = S * Bval.
// Define MULT_FAST_EN to fold the add and shift of each bit into one cycle.
module seq_signed_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ClearA_LoadB,
   input  logic             Run,
   input  logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADD   = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_x;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic [WIDTH-1:0] w_s_nxt;
   logic             w_x_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH:0]   w_addsub;

   // The multiplier's MSB carries negative weight, so the last partial product is subtracted.
   function automatic logic [WIDTH:0] f_addsub(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] s,
      input logic             sub
   );
      logic [WIDTH:0] ea;
      logic [WIDTH:0] es;
      ea = {a[WIDTH-1], a};
      es = {s[WIDTH-1], s};
      if (sub) begin
         return ea - es;
      end else begin
         return ea + es;
      end
   endfunction

   // Partial-product update for the current multiplier bit
   always_comb begin
      if (r_b[0]) begin
         w_addsub = f_addsub(r_a, r_s, r_cnt == LAST_BIT);
      end else begin
         w_addsub = {r_x, r_a};
      end
   end

   // Next-state and datapath next values
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_s_nxt     = r_s;
      w_x_nxt     = r_x;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (ClearA_LoadB) begin
               w_a_nxt = {WIDTH{1'b0}};
               w_x_nxt = 1'b0;
               w_b_nxt = S;
            end else if (Run) begin
               w_a_nxt     = {WIDTH{1'b0}};
               w_x_nxt     = 1'b0;
               w_s_nxt     = S;
               w_cnt_nxt   = {CW{1'b0}};
               w_state_nxt = ST_ADD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
`ifdef MULT_FAST_EN
         ST_ADD: begin
            {w_x_nxt, w_a_nxt, w_b_nxt} = {w_addsub[WIDTH], w_addsub, r_b[WIDTH-1:1]};
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == LAST_BIT) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_ADD;
            end
         end
         ST_SHIFT: begin
            w_state_nxt = ST_IDLE;
         end
`else
         ST_ADD: begin
            {w_x_nxt, w_a_nxt} = w_addsub;
            w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            {w_x_nxt, w_a_nxt, w_b_nxt} = {r_x, r_x, r_a, r_b[WIDTH-1:1]};
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == LAST_BIT) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_ADD;
            end
         end
`endif
         ST_HOLD: begin
            // Wait for Run to drop so a held button yields a single multiply
            if (!Run) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_a     <= {WIDTH{1'b0}};
         r_b     <= {WIDTH{1'b0}};
         r_s     <= {WIDTH{1'b0}};
         r_x     <= 1'b0;
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_s     <= w_s_nxt;
         r_x     <= w_x_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign Aval = r_a;
   assign Bval = r_b;
   assign X    = r_x;
   assign Busy = (r_state == ST_ADD) || (r_state == ST_SHIFT);
   assign Done = (r_state == ST_HOLD);

endmodule
